dot_product_sequencer: RTL and testbench

- Streams operand beats, two element pairs per beat, into the existing 2-multiplier/1-adder pipelined datapath (inputs A1, A2, B1, B2; output C; fixed latency; no reset; no valid).
- Tracks in-flight beats with a tag shift register and accumulates each returned C.
- Presents one dot-product result per job over a valid/ready handshake.
- Sits between the operand-fetch logic and the datapath, and owns all sequencing for it.

---
 rtl/dot_product_sequencer.sv | 103 ++++++++++
 tb/tb_dot_product_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dot_product_sequencer.sv
// Feeds operand beats into a fixed-latency 2-mult/1-add datapath, tags each
// in-flight beat, accumulates the returned products and hands out one sum per job.
module dot_product_sequencer #(
  parameter int LAT   = 3,
  parameter int ACC_W = 40,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a1,
  input  logic [31:0]      in_b1,
  input  logic [31:0]      in_a2,
  input  logic [31:0]      in_b2,
  input  logic             in_last,
  output logic [31:0]      dp_a1,
  output logic [31:0]      dp_b1,
  output logic [31:0]      dp_a2,
  output logic [31:0]      dp_b2,
  input  logic [31:0]      dp_c,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_sum,
  output logic [CNT_W-1:0] res_count,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready, and ready is ignored while valid is low.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [LAT:0]     tag;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] c_ext;
  logic             accept;
  logic             drain_done;

  assign in_ready   = (state == IDLE) || (state == RUN);
  assign accept     = in_valid && in_ready;
  assign c_ext      = ACC_W'(dp_c);
  // Last tagged beat is at the datapath output and nothing else is behind it.
  assign drain_done = tag[LAT] && (tag[LAT-1:0] == '0);
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tag       <= '0;
      dp_a1     <= '0;
      dp_b1     <= '0;
      dp_a2     <= '0;
      dp_b2     <= '0;
      acc       <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_count <= '0;
    end else begin
      dp_a1 <= accept ? in_a1 : 32'd0;
      dp_b1 <= accept ? in_b1 : 32'd0;
      dp_a2 <= accept ? in_a2 : 32'd0;
      dp_b2 <= accept ? in_b2 : 32'd0;
      tag   <= {tag[LAT-1:0], accept};

      if (tag[LAT]) acc <= acc + c_ext;
      if (accept)   cnt <= cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (accept) begin
            acc   <= '0;
            cnt   <= CNT_W'(1);
            state <= in_last ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (accept && in_last) state <= DRAIN;
        end
        DRAIN: begin
          if (drain_done) begin
            res_sum   <= acc + c_ext;
            res_count <= cnt;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer with a 3-stage behavioural datapath
// model; uniform-beat jobs come from a vector table, corner cases are hand-written.
module tb_dot_product_sequencer;

  localparam int ACC_W = 40;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_last;
  logic [31:0]      in_a1, in_b1, in_a2, in_b2;
  logic [31:0]      dp_a1, dp_b1, dp_a2, dp_b2, dp_c;
  logic             res_valid, res_ready;
  logic [ACC_W-1:0] res_sum;
  logic [CNT_W-1:0] res_count;
  logic [1:0]       state_dbg;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dot_product_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a1(in_a1), .in_b1(in_b1), .in_a2(in_a2), .in_b2(in_b2), .in_last(in_last),
    .dp_a1(dp_a1), .dp_b1(dp_b1), .dp_a2(dp_a2), .dp_b2(dp_b2), .dp_c(dp_c),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_count(res_count), .state_dbg(state_dbg)
  );

  // Unreset datapath: samples operands, C appears three edges later.
  logic [31:0] p1, p2, p3;
  always_ff @(posedge clk) begin
    p1 <= dp_a1 * dp_b1 + dp_a2 * dp_b2;
    p2 <= p1;
    p3 <= p2;
  end
  assign dp_c = p3;

  typedef struct {
    logic [31:0]      a1, b1, a2, b2;
    int               beats;
    int               gap;
    logic [ACC_W-1:0] exp_sum;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] a1, b1, a2, b2, input logic last);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a1 = a1; in_b1 = b1; in_a2 = a2; in_b2 = b2; in_last = last;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!res_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, 64'(res_valid), 64'd1);
  endtask

  task automatic handshake();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic get_result(input string name, input logic [ACC_W-1:0] sum,
                            input logic [CNT_W-1:0] cnt);
    wait_valid(name);
    check({name, "_sum"}, 64'(res_sum), 64'(sum));
    check({name, "_count"}, 64'(res_count), 64'(cnt));
    handshake();
  endtask

  initial begin
    vecs[0] = '{32'd2, 32'd3, 32'd4, 32'd5, 1, 0, 40'd26, 16'd1};
    vecs[1] = '{32'hFFFF, 32'hFFFF, 32'd0, 32'd0, 300, 0, 40'h2B_FDA8_012C, 16'd300};
    vecs[2] = '{32'd10, 32'd20, 32'd30, 32'd40, 4, 1, 40'd5600, 16'd4};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1, 0, 40'd1, 16'd1};
    vecs[4] = '{32'h1_0000, 32'h1_0000, 32'd1, 32'd7, 2, 3, 40'd14, 16'd2};
    vecs[5] = '{32'd100, 32'd100, 32'd200, 32'd300, 5, 0, 40'd350000, 16'd5};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; res_ready = 1'b0;
    in_a1 = '0; in_b1 = '0; in_a2 = '0; in_b2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_res_sum", 64'(res_sum), 64'd0);
    check("rst_res_count", 64'(res_count), 64'd0);
    check("rst_dp_a1", 64'(dp_a1), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    rst = 1'b0;

    // Single beat: result valid exactly four edges after acceptance.
    send_beat(32'd2, 32'd3, 32'd4, 32'd5, 1'b1);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("lat_valid_%0d", k), 64'(res_valid), (k == 4) ? 64'd1 : 64'd0);
      check($sformatf("lat_in_ready_%0d", k), 64'(in_ready), 64'd0);
    end
    get_result("single", 40'd26, 16'd1);

    // Three beats with two idle edges before the last.
    send_beat(32'd1, 32'd1, 32'd1, 32'd1, 1'b0);
    send_beat(32'd2, 32'd2, 32'd2, 32'd2, 1'b0);
    repeat (2) @(posedge clk);
    send_beat(32'd3, 32'd3, 32'd3, 32'd3, 1'b1);
    get_result("gapped", 40'd28, 16'd3);

    // Table jobs run back to back: each first beat follows the previous handshake.
    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < vecs[v].beats; b++) begin
        send_beat(vecs[v].a1, vecs[v].b1, vecs[v].a2, vecs[v].b2, b == vecs[v].beats - 1);
        if (b != vecs[v].beats - 1) repeat (vecs[v].gap) @(posedge clk);
      end
      get_result($sformatf("vec%0d", v), vecs[v].exp_sum, vecs[v].exp_cnt);
    end

    // Backpressure: result held for 10 cycles, then released for one edge.
    send_beat(32'd1, 32'd2, 32'd3, 32'd4, 1'b1);
    wait_valid("bp");
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid", 64'(res_valid), 64'd1);
      check("bp_hold_sum", 64'(res_sum), 64'd14);
      check("bp_hold_count", 64'(res_count), 64'd1);
      check("bp_hold_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    handshake();
    @(negedge clk);
    check("bp_after_valid", 64'(res_valid), 64'd0);
    check("bp_after_in_ready", 64'(in_ready), 64'd1);
    send_beat(32'd5, 32'd5, 32'd0, 32'd0, 1'b0);
    send_beat(32'd5, 32'd5, 32'd0, 32'd0, 1'b1);
    get_result("bp_second", 40'd50, 16'd2);

    // Reset while two beats are still inside the datapath.
    send_beat(32'd7, 32'd1, 32'd0, 32'd0, 1'b0);
    send_beat(32'd9, 32'd1, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    check("pre_rst_state", 64'(state_dbg), 64'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_res_valid", 64'(res_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_res_sum", 64'(res_sum), 64'd0);
    check("mid_rst_res_count", 64'(res_count), 64'd0);
    check("mid_rst_dp_a1", 64'(dp_a1), 64'd0);
    check("mid_rst_state", 64'(state_dbg), 64'd0);
    send_beat(32'd1, 32'd1, 32'd0, 32'd0, 1'b1);
    get_result("post_rst", 40'd1, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
